// File: rtl/unsigned_64by32_div_trunc.sv
// Sequential radix-2 restoring divider, 64-bit by 32-bit unsigned, producing only the top
// 32-L quotient bits; the remainder is widened so dividend == quotient*divisor + remainder.
module unsigned_64by32_div_trunc #(
    parameter int unsigned L = 10,
    localparam int unsigned R = 32 + L
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [63:0]   dividend,
    input  logic [31:0]   divisor,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [31:0]   quotient,
    output logic [R-1:0]  remainder,
    output logic          div_by_zero,
    output logic          overflow
);

    localparam logic [4:0]  LastK   = 5'(L);
    localparam logic [31:0] LowMask = 32'((64'd1 << L) - 64'd1);

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e      state_q;
    logic [31:0] lo_q;
    logic [31:0] div_q;
    logic [31:0] r_q;
    logic [31:0] q_q;
    logic [4:0]  k_q;
    logic        zero_q;
    logic        ovf_q;

    logic [32:0]  r_shift;
    logic         q_bit;
    logic [31:0]  r_next;
    logic [31:0]  q_next;
    logic [R-1:0] rem_next;

    assign in_ready = (state_q == StIdle) && !rst;

    // One restoring step; the 33-bit compare keeps the shifted partial remainder from wrapping.
    always_comb begin
        r_shift  = {r_q, lo_q[k_q]};
        q_bit    = r_shift >= {1'b0, div_q};
        r_next   = q_bit ? 32'(r_shift - {1'b0, div_q}) : r_shift[31:0];
        q_next   = q_q | (32'(q_bit) << k_q);
        rem_next = R'({32'b0, r_next} << L) | R'(lo_q & LowMask);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            lo_q        <= '0;
            div_q       <= '0;
            r_q         <= '0;
            q_q         <= '0;
            k_q         <= '0;
            zero_q      <= 1'b0;
            ovf_q       <= 1'b0;
            out_valid   <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        lo_q    <= dividend[31:0];
                        div_q   <= divisor;
                        r_q     <= dividend[63:32];
                        q_q     <= '0;
                        k_q     <= 5'd31;
                        zero_q  <= (divisor == 32'd0);
                        ovf_q   <= (divisor != 32'd0) && (dividend[63:32] >= divisor);
                        state_q <= StBusy;
                    end
                end
                StBusy: begin
                    // Error flags were decided at accept; report them on the first busy edge.
                    if (zero_q || ovf_q) begin
                        state_q     <= StDone;
                        out_valid   <= 1'b1;
                        quotient    <= '1;
                        remainder   <= '0;
                        div_by_zero <= zero_q;
                        overflow    <= ovf_q;
                    end else begin
                        r_q <= r_next;
                        q_q <= q_next;
                        k_q <= k_q - 5'd1;
                        if (k_q == LastK) begin
                            state_q     <= StDone;
                            out_valid   <= 1'b1;
                            quotient    <= q_next;
                            remainder   <= rem_next;
                            div_by_zero <= 1'b0;
                            overflow    <= 1'b0;
                        end
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        state_q   <= StIdle;
                        out_valid <= 1'b0;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_unsigned_64by32_div_trunc.sv
// Directed and invariant-checked bench for the truncated divider at L = 0, 10 and 31.
module tb_unsigned_64by32_div_trunc;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid_s  [3];
    logic        in_ready_s  [3];
    logic [63:0] dividend_s  [3];
    logic [31:0] divisor_s   [3];
    logic        out_valid_s [3];
    logic        out_ready_s [3];
    logic [31:0] quotient_s  [3];
    logic        dz_s        [3];
    logic        ov_s        [3];
    logic [31:0] rem0;
    logic [41:0] rem10;
    logic [62:0] rem31;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    unsigned_64by32_div_trunc #(.L(0)) u0 (
        .clk(clk), .rst(rst), .in_valid(in_valid_s[0]), .in_ready(in_ready_s[0]),
        .dividend(dividend_s[0]), .divisor(divisor_s[0]), .out_valid(out_valid_s[0]),
        .out_ready(out_ready_s[0]), .quotient(quotient_s[0]), .remainder(rem0),
        .div_by_zero(dz_s[0]), .overflow(ov_s[0])
    );
    unsigned_64by32_div_trunc #(.L(10)) u10 (
        .clk(clk), .rst(rst), .in_valid(in_valid_s[1]), .in_ready(in_ready_s[1]),
        .dividend(dividend_s[1]), .divisor(divisor_s[1]), .out_valid(out_valid_s[1]),
        .out_ready(out_ready_s[1]), .quotient(quotient_s[1]), .remainder(rem10),
        .div_by_zero(dz_s[1]), .overflow(ov_s[1])
    );
    unsigned_64by32_div_trunc #(.L(31)) u31 (
        .clk(clk), .rst(rst), .in_valid(in_valid_s[2]), .in_ready(in_ready_s[2]),
        .dividend(dividend_s[2]), .divisor(divisor_s[2]), .out_valid(out_valid_s[2]),
        .out_ready(out_ready_s[2]), .quotient(quotient_s[2]), .remainder(rem31),
        .div_by_zero(dz_s[2]), .overflow(ov_s[2])
    );

    function automatic logic [62:0] rem_of(input int sel);
        case (sel)
            0:       return 63'(rem0);
            1:       return 63'(rem10);
            default: return rem31;
        endcase
    endfunction

    // Latency counts edges after the accept edge until out_valid is seen high.
    task automatic do_op(input int sel, input logic [63:0] dd, input logic [31:0] ds,
                         output logic [31:0] q, output logic [62:0] rm, output logic dz,
                         output logic ov, output int lat);
        int w = 0;
        in_valid_s[sel] = 1'b1;
        dividend_s[sel] = dd;
        divisor_s[sel]  = ds;
        while (!in_ready_s[sel] && w < 50) begin
            @(posedge clk); #1; w++;
        end
        @(posedge clk); #1;
        in_valid_s[sel] = 1'b0;
        lat = 0;
        while (!out_valid_s[sel] && lat < 100) begin
            @(posedge clk); #1; lat++;
        end
        q  = quotient_s[sel];
        rm = rem_of(sel);
        dz = dz_s[sel];
        ov = ov_s[sel];
        out_ready_s[sel] = 1'b1;
        @(posedge clk); #1;
        out_ready_s[sel] = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        for (int s = 0; s < 3; s++) begin
            n_cmp++;
            if ({in_ready_s[s], out_valid_s[s], dz_s[s], ov_s[s]} !== 4'b0000) begin
                n_bad++;
                $display("FAIL reset_flags[%0d]: got %b want 0000", s,
                         {in_ready_s[s], out_valid_s[s], dz_s[s], ov_s[s]});
            end
            n_cmp++;
            if (quotient_s[s] !== 32'd0 || rem_of(s) !== 63'd0) begin
                n_bad++;
                $display("FAIL reset_data[%0d]: got q=%h r=%h want 0", s, quotient_s[s],
                         rem_of(s));
            end
        end
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        for (int s = 0; s < 3; s++) begin
            n_cmp++;
            if (in_ready_s[s] !== 1'b1) begin
                n_bad++;
                $display("FAIL reset_release_ready[%0d]: got %b want 1", s, in_ready_s[s]);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_exact();
        logic [31:0] q; logic [62:0] rm; logic dz, ov; int lat;
        do_op(0, 64'd100, 32'd7, q, rm, dz, ov, lat);
        n_cmp++;
        if (q !== 32'd14 || rm !== 63'd2 || dz !== 1'b0 || ov !== 1'b0) begin
            n_bad++;
            $display("FAIL exact_100_7: got q=%0d r=%0d dz=%b ov=%b want 14 2 0 0", q, rm, dz, ov);
        end
        n_cmp++;
        if (lat !== 32) begin
            n_bad++;
            $display("FAIL exact_latency: got %0d want 32", lat);
        end
    endtask

    task automatic test_truncated();
        logic [31:0] q; logic [62:0] rm; logic dz, ov; int lat;
        do_op(1, 64'h00000000_FFFFFFFF, 32'd3, q, rm, dz, ov, lat);
        n_cmp++;
        if (q !== 32'h55555400 || rm !== 63'h3FF || dz !== 1'b0 || ov !== 1'b0) begin
            n_bad++;
            $display("FAIL trunc_ffffffff_3: got q=%h r=%h dz=%b ov=%b want 55555400 3ff 0 0",
                     q, rm, dz, ov);
        end
        n_cmp++;
        if (lat !== 22) begin
            n_bad++;
            $display("FAIL trunc_latency: got %0d want 22", lat);
        end
    endtask

    task automatic test_errors();
        logic [31:0] q; logic [62:0] rm; logic dz, ov; int lat;
        do_op(1, 64'd123, 32'd0, q, rm, dz, ov, lat);
        n_cmp++;
        if (q !== 32'hFFFFFFFF || rm !== 63'd0 || dz !== 1'b1 || ov !== 1'b0 || lat !== 1) begin
            n_bad++;
            $display("FAIL div_by_zero: got q=%h r=%h dz=%b ov=%b lat=%0d want ffffffff 0 1 0 1",
                     q, rm, dz, ov, lat);
        end
        do_op(1, 64'h00000005_00000000, 32'd5, q, rm, dz, ov, lat);
        n_cmp++;
        if (q !== 32'hFFFFFFFF || rm !== 63'd0 || dz !== 1'b0 || ov !== 1'b1 || lat !== 1) begin
            n_bad++;
            $display("FAIL overflow: got q=%h r=%h dz=%b ov=%b lat=%0d want ffffffff 0 0 1 1",
                     q, rm, dz, ov, lat);
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        in_valid_s[1] = 1'b1;
        dividend_s[1] = 64'd10_000_000;
        divisor_s[1]  = 32'd10;
        @(posedge clk); #1;
        // Second operation queued immediately; it must not disturb the one in flight.
        dividend_s[1] = 64'h00000001_00000000;
        divisor_s[1]  = 32'd2;
        lat = 0;
        while (!out_valid_s[1] && lat < 100) begin
            @(posedge clk); #1; lat++;
        end
        n_cmp++;
        if (lat !== 22) begin
            n_bad++;
            $display("FAIL bp_latency: got %0d want 22", lat);
        end
        for (int i = 0; i < 5; i++) begin
            n_cmp++;
            if (out_valid_s[1] !== 1'b1 || in_ready_s[1] !== 1'b0 ||
                quotient_s[1] !== 32'h000F4000 || rem10 !== 42'd5760) begin
                n_bad++;
                $display("FAIL bp_hold[%0d]: got v=%b rdy=%b q=%h r=%0d want 1 0 000f4000 5760",
                         i, out_valid_s[1], in_ready_s[1], quotient_s[1], rem10);
            end
            @(posedge clk); #1;
        end
        out_ready_s[1] = 1'b1;
        @(posedge clk); #1;
        out_ready_s[1] = 1'b0;
        n_cmp++;
        if (out_valid_s[1] !== 1'b0 || in_ready_s[1] !== 1'b1) begin
            n_bad++;
            $display("FAIL bp_release: got v=%b rdy=%b want 0 1", out_valid_s[1], in_ready_s[1]);
        end
        @(posedge clk); #1;
        in_valid_s[1] = 1'b0;
        n_cmp++;
        if (in_ready_s[1] !== 1'b0) begin
            n_bad++;
            $display("FAIL bp_second_accept: got rdy=%b want 0", in_ready_s[1]);
        end
        lat = 0;
        while (!out_valid_s[1] && lat < 100) begin
            @(posedge clk); #1; lat++;
        end
        n_cmp++;
        if (quotient_s[1] !== 32'h80000000 || rem10 !== 42'd0 || lat !== 22) begin
            n_bad++;
            $display("FAIL bp_second_result: got q=%h r=%h lat=%0d want 80000000 0 22",
                     quotient_s[1], rem10, lat);
        end
        out_ready_s[1] = 1'b1;
        @(posedge clk); #1;
        out_ready_s[1] = 1'b0;
    endtask

    task automatic test_reset_busy();
        logic [31:0] q; logic [62:0] rm; logic dz, ov; int lat; int seen = 0;
        in_valid_s[0] = 1'b1;
        dividend_s[0] = 64'h00000003_12345678;
        divisor_s[0]  = 32'h0000_1234;
        @(posedge clk); #1;
        in_valid_s[0] = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({out_valid_s[0], in_ready_s[0], dz_s[0], ov_s[0]} !== 4'b0000 ||
            quotient_s[0] !== 32'd0 || rem0 !== 32'd0) begin
            n_bad++;
            $display("FAIL reset_busy: got v=%b rdy=%b dz=%b ov=%b q=%h r=%h want all 0",
                     out_valid_s[0], in_ready_s[0], dz_s[0], ov_s[0], quotient_s[0], rem0);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        n_cmp++;
        if (in_ready_s[0] !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_busy_ready: got %b want 1", in_ready_s[0]);
        end
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (out_valid_s[0]) seen++;
        end
        n_cmp++;
        if (seen !== 0) begin
            n_bad++;
            $display("FAIL reset_busy_no_result: got %0d valid cycles want 0", seen);
        end
        do_op(0, 64'd1000, 32'd10, q, rm, dz, ov, lat);
        n_cmp++;
        if (q !== 32'd100 || rm !== 63'd0 || dz !== 1'b0 || ov !== 1'b0 || lat !== 32) begin
            n_bad++;
            $display("FAIL reset_busy_next_op: got q=%0d r=%0d dz=%b ov=%b lat=%0d want 100 0 0 0 32",
                     q, rm, dz, ov, lat);
        end
    endtask

    task automatic test_random();
        int          lsel [3] = '{0, 10, 31};
        logic [31:0] q    [3];
        logic [62:0] rm   [3];
        logic        dz   [3];
        logic        ov   [3];
        int          lt   [3];
        logic [63:0] dd, eq, er, mask;
        logic [31:0] ds;
        for (int it = 0; it < 2000; it++) begin
            ds = (it % 4 == 0) ? 32'($urandom_range(1, 1000)) : 32'($urandom);
            if (ds == 32'd0) ds = 32'd1;
            dd = {32'($urandom) % ds, 32'($urandom)};
            fork
                do_op(0, dd, ds, q[0], rm[0], dz[0], ov[0], lt[0]);
                do_op(1, dd, ds, q[1], rm[1], dz[1], ov[1], lt[1]);
                do_op(2, dd, ds, q[2], rm[2], dz[2], ov[2], lt[2]);
            join
            for (int s = 0; s < 3; s++) begin
                mask = (64'd1 << lsel[s]) - 64'd1;
                eq   = (dd / 64'(ds)) & ~mask;
                er   = dd - eq * 64'(ds);
                n_cmp++;
                if (q[s] !== eq[31:0] || 64'(rm[s]) !== er) begin
                    n_bad++;
                    $display("FAIL rand_value L=%0d dd=%h ds=%h: got q=%h r=%h want q=%h r=%h",
                             lsel[s], dd, ds, q[s], rm[s], eq[31:0], er);
                end
                n_cmp++;
                if (64'(q[s]) * 64'(ds) + 64'(rm[s]) !== dd) begin
                    n_bad++;
                    $display("FAIL rand_identity L=%0d dd=%h ds=%h: got q=%h r=%h",
                             lsel[s], dd, ds, q[s], rm[s]);
                end
                n_cmp++;
                if (!(64'(rm[s]) < (64'(ds) << lsel[s]))) begin
                    n_bad++;
                    $display("FAIL rand_rem_bound L=%0d ds=%h: got r=%h want below %h",
                             lsel[s], ds, rm[s], 64'(ds) << lsel[s]);
                end
                n_cmp++;
                if (dz[s] !== 1'b0 || ov[s] !== 1'b0 || lt[s] !== 32 - lsel[s]) begin
                    n_bad++;
                    $display("FAIL rand_flags_lat L=%0d: got dz=%b ov=%b lat=%0d want 0 0 %0d",
                             lsel[s], dz[s], ov[s], lt[s], 32 - lsel[s]);
                end
            end
        end
    endtask

    initial begin
        for (int s = 0; s < 3; s++) begin
            in_valid_s[s]  = 1'b0;
            out_ready_s[s] = 1'b0;
            dividend_s[s]  = '0;
            divisor_s[s]   = '0;
        end
        test_reset();
        test_exact();
        test_truncated();
        test_errors();
        test_back_to_back();
        test_reset_busy();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
